// File: rtl/mem_arbiter.sv
// Purpose: shares one byte-wide RAM between instruction fetch and the load/store port, splitting words/halves into byte accesses.
// Latency: request seen in IDLE at cycle 0; ready at cycle N+1 (stores) or N+2 (loads/fetch), N = byte count.
// Backpressure: requesters hold req until their ready pulse; a losing requester waits for the whole other transaction.
module mem_arbiter #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, CAP, DONE} state_t;

  state_t              state_q, state_d;
  logic                port_q, port_d;        // 1 = data port owns the transaction
  logic                last_d_q, last_d_d;    // 1 = data port was granted most recently
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          last_idx_q, last_idx_d; // index of the final byte (N-1)
  logic [1:0]          cnt_q, cnt_d;
  logic [31:0]         result_q, result_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                grant_data;
  logic [1:0]          prev_idx;

  // Next-state logic: arbitration in IDLE, byte sequencing in XFER, final capture in CAP.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    last_d_d   = last_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    last_idx_d = last_idx_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    grant_data = 1'b0;
    prev_idx   = cnt_q - 2'd1;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // On a tie the port that did not win last time gets the RAM.
          grant_data = d_req && (!if_req || !last_d_q);
          port_d     = grant_data;
          last_d_d   = grant_data;
          addr_d     = grant_data ? d_addr : if_addr;
          we_d       = grant_data && d_we;
          wdata_d    = d_wdata;
          if (!grant_data || d_size[1]) last_idx_d = 2'd3;
          else if (d_size[0])           last_idx_d = 2'd1;
          else                          last_idx_d = 2'd0;
          cnt_d      = 2'd0;
          result_d   = 32'd0;
          state_d    = XFER;
        end
      end
      XFER: begin
        // RAM read data lags the address by one cycle, so this cycle sees byte cnt-1.
        if (!we_q && cnt_q != 2'd0) result_d[{prev_idx, 3'b000} +: 8] = ram_rdata;
        if (cnt_q == last_idx_q) state_d = we_q ? DONE : CAP;
        else                     cnt_d   = cnt_q + 2'd1;
      end
      CAP: begin
        result_d[{last_idx_q, 3'b000} +: 8] = ram_rdata;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM side: address walks during XFER and otherwise holds; a reset cycle never writes.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_we     = 1'b0;
    ram_wdata  = 8'd0;
    if (state_q == XFER) begin
      ram_addr_d = addr_q + ADDR_W'(cnt_q);
      ram_we     = we_q && !rst;
      if (we_q) ram_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
    end
    ram_addr = ram_addr_d;
  end

  // Core side: ready pulses and result only in DONE, for the owning port.
  always_comb begin
    if_ready = (state_q == DONE) && !port_q;
    d_ready  = (state_q == DONE) && port_q;
    if_rdata = if_ready ? result_q : 32'd0;
    d_rdata  = d_ready  ? result_q : 32'd0;
    busy     = (state_q != IDLE);
  end

  // State registers with synchronous reset; last-granted resets to data so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= 1'b0;
      last_d_q   <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      last_idx_q <= 2'd0;
      cnt_q      <= 2'd0;
      result_q   <= 32'd0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      last_d_q   <= last_d_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      last_idx_q <= last_idx_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      ram_addr_q <= ram_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a byte RAM and a transaction-level reference.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Requests are held until ready, mirroring the core's handshake.
module tb_mem_arbiter;
  localparam int ADDR_W = 9;
  localparam int MSZ    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ready;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [1:0]        d_size = 2'd0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic              d_ready;
  logic [31:0]       d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata = 8'd0;
  logic              busy;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem     [MSZ];
  logic [7:0] ref_mem [MSZ];
  bit         last_was_data = 1'b1;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte RAM: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int nbytes(input bit is_data, input logic [1:0] size);
    if (!is_data || size[1]) return 4;
    return size[0] ? 2 : 1;
  endfunction

  // Reference read: little-endian bytes from the model RAM, wrapping, zero-extended.
  function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a, input int n);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[(int'(a) + i) % MSZ];
    return r;
  endfunction

  task automatic ref_write(input logic [ADDR_W-1:0] a, input int n, input logic [31:0] w);
    for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % MSZ] = w[8*i +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // One uncontended transaction, checked against the model for latency, data and the quiet port.
  task automatic xact(input bit is_data, input bit we, input logic [1:0] size,
                      input logic [ADDR_W-1:0] a, input logic [31:0] w,
                      output logic [31:0] rdata);
    int n, cyc, exp_lat;
    bit done, other_seen;
    logic [31:0] exp_data;
    wait_idle();
    n        = nbytes(is_data, size);
    exp_lat  = (is_data && we) ? n + 1 : n + 2;
    exp_data = ref_read(a, n);
    if (is_data) begin
      d_we = we; d_size = size; d_addr = a; d_wdata = w; d_req = 1'b1;
    end else begin
      if_addr = a; if_req = 1'b1;
    end
    cyc = 0; done = 1'b0; other_seen = 1'b0; rdata = 32'd0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      other_seen |= is_data ? if_ready : d_ready;
      if (is_data ? d_ready : if_ready) begin
        done  = 1'b1;
        rdata = is_data ? d_rdata : if_rdata;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    chk(is_data ? "d_latency" : "if_latency", cyc, exp_lat);
    chk("other_ready_quiet", {31'd0, other_seen}, 32'd0);
    if (is_data && we) ref_write(a, n, w);
    else chk(is_data ? "d_rdata" : "if_rdata", rdata, exp_data);
    last_was_data = is_data;
  endtask

  // Both ports request together; the winner is whichever did not win last.
  task automatic tie(input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] da);
    int cyc = 0, if_at = 0, d_at = 0;
    logic [31:0] if_got = 0, d_got = 0;
    logic [31:0] if_exp, d_exp;
    bit fetch_wins;
    wait_idle();
    fetch_wins = last_was_data;
    if_exp = ref_read(fa, 4);
    d_exp  = ref_read(da, 4);
    if_addr = fa; d_addr = da; d_we = 1'b0; d_size = 2'd2;
    if_req = 1'b1; d_req = 1'b1;
    while ((if_at == 0 || d_at == 0) && cyc < 40) begin
      tick();
      cyc++;
      if (if_ready) begin if_at = cyc; if_got = if_rdata; if_req = 1'b0; end
      if (d_ready)  begin d_at = cyc;  d_got = d_rdata;  d_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    chk("tie_if_cycle", if_at, fetch_wins ? 6 : 13);
    chk("tie_d_cycle",  d_at,  fetch_wins ? 13 : 6);
    chk("tie_if_rdata", if_got, if_exp);
    chk("tie_d_rdata",  d_got,  d_exp);
    last_was_data = fetch_wins;
  endtask

  initial begin : main
    logic [31:0] r;
    int busy_low, if_first, if_second, cyc, bad;
    bit d_seen;

    for (int i = 0; i < MSZ; i++) begin
      mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_outputs", {if_ready, d_ready, ram_we, busy, ram_wdata}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);

    // Word store then word load at 0x010.
    xact(1, 1, 2'd2, 9'h010, 32'hDEADBEEF, r);
    chk("store_bytes", {mem[9'h013], mem[9'h012], mem[9'h011], mem[9'h010]}, 32'hDEADBEEF);
    xact(1, 0, 2'd2, 9'h010, 32'd0, r);
    chk("word_load_const", r, 32'hDEADBEEF);
    xact(1, 0, 2'd0, 9'h012, 32'd0, r);
    chk("byte_load_const", r, 32'h000000AD);
    xact(1, 0, 2'd1, 9'h011, 32'd0, r);
    chk("half_load_const", r, 32'h0000ADBE);

    // Ties: fetch wins the first, then after a lone fetch the data port wins.
    tie(9'h010, 9'h010);
    xact(0, 0, 2'd2, 9'h100, 32'd0, r);
    tie(9'h011, 9'h00F);

    // Wrap across the top of the address space.
    xact(1, 1, 2'd3, 9'h1FE, 32'h11223344, r);
    chk("wrap_bytes", {mem[9'h001], mem[9'h000], mem[9'h1FF], mem[9'h1FE]}, 32'h11223344);
    xact(0, 0, 2'd2, 9'h1FE, 32'd0, r);
    chk("wrap_fetch_const", r, 32'h11223344);

    // Reset in the XFER cycle with cnt=2 of a word store.
    xact(1, 1, 2'd2, 9'h020, 32'h00000000, r);
    wait_idle();
    d_we = 1'b1; d_size = 2'd2; d_addr = 9'h020; d_wdata = 32'hAABBCCDD; d_req = 1'b1;
    d_seen = 1'b0;
    repeat (3) begin tick(); d_seen |= d_ready; end
    rst = 1'b1; d_req = 1'b0;
    tick();
    chk("rst_mid_we_busy", {30'd0, ram_we, busy}, 32'd0);
    d_seen |= d_ready;
    rst = 1'b0;
    repeat (3) begin tick(); d_seen |= d_ready; end
    chk("rst_mid_no_ready", {31'd0, d_seen}, 32'd0);
    chk("rst_mid_bytes", {mem[9'h023], mem[9'h022], mem[9'h021], mem[9'h020]}, 32'h0000CCDD);
    ref_mem[9'h020] = 8'hDD;
    ref_mem[9'h021] = 8'hCC;
    last_was_data = 1'b1;
    tie(9'h020, 9'h1FE);

    // Fetch request held across ready: a back-to-back fetch after one IDLE cycle.
    wait_idle();
    if_addr = 9'h010; if_req = 1'b1;
    busy_low = 0; if_first = 0; if_second = 0; cyc = 0;
    while (if_second == 0 && cyc < 40) begin
      tick();
      cyc++;
      if (!busy) busy_low++;
      if (if_ready) begin
        if (if_first == 0) if_first = cyc;
        else begin if_second = cyc; if_req = 1'b0; end
      end
    end
    if_req = 1'b0;
    tick();
    chk("held_first", if_first, 6);
    chk("held_second", if_second, 13);
    chk("held_busy_low", busy_low, 1);
    last_was_data = 1'b0;

    // Randomized single-port traffic against the reference.
    for (int k = 0; k < 40; k++) begin
      bit pd, we;
      logic [1:0] sz;
      logic [ADDR_W-1:0] a;
      pd = 1'($urandom_range(0, 1));
      we = pd && 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ADDR_W'($urandom_range(0, MSZ - 1));
      xact(pd, we, sz, a, $urandom, r);
    end
    tie(9'h1FF, 9'h0AB);

    bad = 0;
    for (int i = 0; i < MSZ; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("ram_image", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
